// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter: I-cache line fills and load/store
// transfers share one RAM port, round-robin on conflict.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rollback,
  input  logic [7:0]   mem_din,
  output logic [7:0]   mem_dout,
  output logic [31:0]  mem_a,
  output logic         mem_wr,
  input  logic         io_buffer_full,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  output logic [511:0] if_row,
  output logic         if_done,
  input  logic         ls_req,
  input  logic         ls_we,
  input  logic [1:0]   ls_size,
  input  logic [31:0]  ls_addr,
  input  logic [31:0]  ls_wdata,
  output logic [31:0]  ls_rdata,
  output logic         ls_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IFRD = 3'd1;
  localparam logic [2:0] S_LSRD = 3'd2;
  localparam logic [2:0] S_LSWR = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]   state_q;
  logic [6:0]   cnt_q;
  logic [6:0]   n_q;
  logic         pend_q;
  logic         rdy_q;
  logic         last_ls_q;
  logic [31:0]  addr_q;
  logic [7:0]   dout_q;
  logic         ifd_q;
  logic         lsd_q;
  logic [511:0] row_q;
  logic [31:0]  rdata_q;
  logic [511:0] buf_q;
  logic [511:0] buf_d;

  logic [6:0] ls_n;
  logic [5:0] cap_idx;
  logic [1:0] wsel;
  logic       io_stall;
  logic       lost;
  logic       pick_ls;

  assign ls_n    = (ls_size == 2'b00) ? 7'd1 :
                   (ls_size == 2'b01) ? 7'd2 : 7'd4;
  assign cap_idx = cnt_q[5:0] - 6'd1;
  assign wsel    = cnt_q[1:0] + 2'd1;
  assign io_stall = (addr_q[17:16] == 2'b11) && io_buffer_full;
  // a byte addressed before a stall cycle never reached us
  assign lost    = pend_q && !rdy_q;
  assign pick_ls = ls_req && (!if_req || !last_ls_q);

  assign mem_a    = addr_q;
  assign mem_dout = dout_q;
  assign mem_wr   = !rst && rdy && (state_q == S_LSWR) && !io_stall;
  assign if_row   = row_q;
  assign if_done  = ifd_q;
  assign ls_rdata = rdata_q;
  assign ls_done  = lsd_q;

  // merge the byte arriving this cycle into the fill buffer
  always_comb begin
    buf_d = buf_q;
    buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  // arbitration, byte sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      pend_q    <= 1'b0;
      rdy_q     <= 1'b0;
      last_ls_q <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      ifd_q     <= 1'b0;
      lsd_q     <= 1'b0;
      row_q     <= '0;
      rdata_q   <= '0;
      buf_q     <= '0;
    end else begin
      rdy_q <= rdy;
      if (rdy) begin
        ifd_q <= 1'b0;
        lsd_q <= 1'b0;
        unique case (state_q)
          S_IDLE: begin
            if (!rollback && (if_req || ls_req)) begin
              cnt_q  <= '0;
              pend_q <= 1'b0;
              buf_q  <= '0;
              if (pick_ls) begin
                last_ls_q <= 1'b1;
                addr_q    <= ls_addr;
                dout_q    <= ls_wdata[7:0];
                n_q       <= ls_n;
                state_q   <= ls_we ? S_LSWR : S_LSRD;
              end else begin
                last_ls_q <= 1'b0;
                addr_q    <= if_addr & ~32'h3F;
                n_q       <= 7'd64;
                state_q   <= S_IFRD;
              end
            end
          end
          S_IFRD, S_LSRD: begin
            if (rollback) begin
              state_q <= S_IDLE;
              pend_q  <= 1'b0;
            end else if (lost) begin
              addr_q <= addr_q - 32'd1;
              cnt_q  <= cnt_q - 7'd1;
              pend_q <= 1'b0;
            end else begin
              if (pend_q) buf_q <= buf_d;
              if (pend_q && cnt_q == n_q) begin
                state_q <= S_DONE;
                pend_q  <= 1'b0;
                if (state_q == S_IFRD) begin
                  row_q <= buf_d;
                  ifd_q <= 1'b1;
                end else begin
                  rdata_q <= buf_d[31:0];
                  lsd_q   <= 1'b1;
                end
              end else begin
                pend_q <= 1'b1;
                cnt_q  <= cnt_q + 7'd1;
                addr_q <= addr_q + 32'd1;
              end
            end
          end
          S_LSWR: begin
            if (!io_stall) begin
              cnt_q  <= cnt_q + 7'd1;
              addr_q <= addr_q + 32'd1;
              dout_q <= ls_wdata[{wsel, 3'b000} +: 8];
              if (cnt_q + 7'd1 == n_q) begin
                state_q <= S_DONE;
                lsd_q   <= 1'b1;
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle schedule model
// of addresses, strobes and done pulses, plus data literals.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst, rdy, rollback;
  logic [7:0]   mem_din, mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr, io_buffer_full;
  logic         if_req, if_done, ls_req, ls_we, ls_done;
  logic [31:0]  if_addr, ls_addr, ls_wdata, ls_rdata;
  logic [1:0]   ls_size;
  logic [511:0] if_row;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  localparam int NC = 1024;
  bit          exp_av  [NC];
  logic [31:0] exp_a   [NC];
  bit          exp_wr  [NC];
  logic [7:0]  exp_do  [NC];
  bit          exp_ifd [NC];
  bit          exp_lsd [NC];

  logic [7:0] ram [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM: one-cycle read latency, write on strobe
  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
  end

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_row(if_row),
    .if_done(if_done), .ls_req(ls_req), .ls_we(ls_we),
    .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_done(ls_done)
  );

  function automatic logic [7:0] init_val(input int i);
    int v;
    case (i)
      256: return 8'h11;
      257: return 8'h22;
      258: return 8'h33;
      259: return 8'h44;
      default: begin
        v = i * 7 + 3;
        return v[7:0];
      end
    endcase
  endfunction

  function automatic logic [511:0] row_of(input int base);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++)
      r[8*k +: 8] = init_val((base + k) % 1024);
    return r;
  endfunction

  task automatic check(input string nm,
                       input logic [511:0] act,
                       input logic [511:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  // read of n bytes accepted at edge ending t; frz stall
  // cycles (rdy low) right after the accept
  task automatic sched_rd(input int t, input int base,
                          input int n, input int frz,
                          input bit isif);
    for (int f = 0; f <= frz; f++) begin
      exp_av[t+1+f] = 1'b1;
      exp_a[t+1+f]  = base;
    end
    for (int k = 1; k < n; k++) begin
      exp_av[t+1+frz+k] = 1'b1;
      exp_a[t+1+frz+k]  = base + k;
    end
    if (isif) exp_ifd[t+n+2+frz] = 1'b1;
    else      exp_lsd[t+n+2+frz] = 1'b1;
  endtask

  // store of n bytes, IO sink full for st cycles first
  task automatic sched_wr(input int t, input int base,
                          input int n, input logic [31:0] wd,
                          input int st);
    for (int s = 0; s < st; s++) begin
      exp_av[t+1+s] = 1'b1;
      exp_a[t+1+s]  = base;
    end
    for (int k = 0; k < n; k++) begin
      exp_av[t+1+st+k] = 1'b1;
      exp_a[t+1+st+k]  = base + k;
      exp_wr[t+1+st+k] = 1'b1;
      exp_do[t+1+st+k] = wd[8*k +: 8];
    end
    exp_lsd[t+n+1+st] = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // per-cycle compare against the schedule
  always @(negedge clk) begin
    if (chk_en && cyc < NC) begin
      check("mem_wr", {511'd0, mem_wr}, {511'd0, exp_wr[cyc]});
      check("if_done", {511'd0, if_done},
            {511'd0, exp_ifd[cyc]});
      check("ls_done", {511'd0, ls_done},
            {511'd0, exp_lsd[cyc]});
      if (exp_av[cyc])
        check("mem_a", {480'd0, mem_a}, {480'd0, exp_a[cyc]});
      if (exp_wr[cyc])
        check("mem_dout", {504'd0, mem_dout},
              {504'd0, exp_do[cyc]});
    end
  end

  initial begin
    int t, t1, t2, t3;
    for (int i = 0; i < 1024; i++) ram[i] = init_val(i);
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00;
    ls_addr = '0; ls_wdata = '0;
    step(3);
    check("rst_mem_a", {480'd0, mem_a}, 512'd0);
    check("rst_mem_dout", {504'd0, mem_dout}, 512'd0);
    check("rst_mem_wr", {511'd0, mem_wr}, 512'd0);
    check("rst_if_done", {511'd0, if_done}, 512'd0);
    check("rst_ls_done", {511'd0, ls_done}, 512'd0);
    check("rst_if_row", if_row, 512'd0);
    check("rst_ls_rdata", {480'd0, ls_rdata}, 512'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // first conflict goes to LS, then IF
    t = cyc;
    ls_req = 1'b1; ls_size = 2'b10; ls_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h1234;
    sched_rd(t, 32'h100, 4, 0, 1'b0);
    t1 = t + 7;
    sched_rd(t1, 32'h1200, 64, 0, 1'b1);
    step(6);
    check("word_load", {480'd0, ls_rdata}, {480'd0, 32'h44332211});
    ls_req = 1'b0;
    step(t1 + 66 - cyc);
    check("if_row_1200", if_row, row_of(32'h1200));
    check("rdata_stable", {480'd0, ls_rdata},
          {480'd0, 32'h44332211});
    if_req = 1'b0;
    step(1);

    // second conflict: LS again, then IF
    t2 = cyc;
    ls_req = 1'b1; ls_size = 2'b01; ls_addr = 32'h102;
    if_req = 1'b1; if_addr = 32'h12C5;
    sched_rd(t2, 32'h102, 2, 0, 1'b0);
    t3 = t2 + 5;
    sched_rd(t3, 32'h12C0, 64, 0, 1'b1);
    step(4);
    check("half_load", {480'd0, ls_rdata}, {480'd0, 32'h00004433});
    check("row_stable", if_row, row_of(32'h1200));
    ls_req = 1'b0;
    step(t3 + 66 - cyc);
    check("if_row_12c0", if_row, row_of(32'h12C0));
    if_req = 1'b0;
    step(1);

    // byte load
    t = cyc;
    ls_req = 1'b1; ls_size = 2'b00; ls_addr = 32'h101;
    sched_rd(t, 32'h101, 1, 0, 1'b0);
    step(3);
    check("byte_load", {480'd0, ls_rdata}, {480'd0, 32'h22});
    ls_req = 1'b0;
    step(1);

    // size 11 behaves as a word
    t = cyc;
    ls_req = 1'b1; ls_size = 2'b11; ls_addr = 32'h101;
    sched_rd(t, 32'h101, 4, 0, 1'b0);
    step(6);
    check("size11_load", {480'd0, ls_rdata},
          {480'd0, 32'h1F443322});
    ls_req = 1'b0;
    step(1);

    // IO store stalled by a full sink
    t = cyc;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00;
    ls_addr = 32'h30000; ls_wdata = 32'h41;
    sched_wr(t, 32'h30000, 1, 32'h41, 3);
    step(1);
    io_buffer_full = 1'b1;
    step(3);
    io_buffer_full = 1'b0;
    step(1);
    ls_req = 1'b0; ls_we = 1'b0;
    check("io_store_ram", {504'd0, ram[0]}, {504'd0, 8'h41});
    step(1);

    // rollback aborts a fill; pending load goes next
    t = cyc;
    if_req = 1'b1; if_addr = 32'h1234;
    for (int k = 0; k < 10; k++) begin
      exp_av[t+1+k] = 1'b1;
      exp_a[t+1+k]  = 32'h1200 + k;
    end
    sched_rd(t + 11, 32'h100, 4, 0, 1'b0);
    step(5);
    ls_req = 1'b1; ls_size = 2'b10; ls_addr = 32'h100;
    step(5);
    rollback = 1'b1;
    step(1);
    rollback = 1'b0; if_req = 1'b0;
    step(6);
    check("rb_then_load", {480'd0, ls_rdata},
          {480'd0, 32'h44332211});
    ls_req = 1'b0;
    step(1);

    // stores ignore rollback
    t = cyc;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10;
    ls_addr = 32'h380; ls_wdata = 32'hDEADBEEF;
    sched_wr(t, 32'h380, 4, 32'hDEADBEEF, 0);
    step(2);
    rollback = 1'b1;
    step(2);
    rollback = 1'b0;
    step(1);
    ls_req = 1'b0; ls_we = 1'b0;
    check("rb_store_ram",
          {480'd0, ram[899], ram[898], ram[897], ram[896]},
          {480'd0, 32'hDEADBEEF});
    step(1);

    // rdy low for 3 cycles delays the load by 3
    t = cyc;
    ls_req = 1'b1; ls_size = 2'b10; ls_addr = 32'h100;
    sched_rd(t, 32'h100, 4, 3, 1'b0);
    step(1);
    rdy = 1'b0;
    step(3);
    rdy = 1'b1;
    step(5);
    check("rdy_load", {480'd0, ls_rdata}, {480'd0, 32'h44332211});
    ls_req = 1'b0;
    step(1);

    // rollback in IDLE blocks the accept for one cycle
    t = cyc;
    ls_req = 1'b1; ls_size = 2'b01; ls_addr = 32'h102;
    rollback = 1'b1;
    sched_rd(t + 1, 32'h102, 2, 0, 1'b0);
    step(1);
    rollback = 1'b0;
    step(4);
    check("idle_rb_load", {480'd0, ls_rdata},
          {480'd0, 32'h00004433});
    ls_req = 1'b0;
    step(1);

    // reset truncates a store in flight
    t = cyc;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10;
    ls_addr = 32'h3C0; ls_wdata = 32'h11223344;
    exp_av[t+1] = 1'b1; exp_a[t+1] = 32'h3C0;
    exp_wr[t+1] = 1'b1; exp_do[t+1] = 8'h44;
    step(2);
    rst = 1'b1;
    ls_req = 1'b0; ls_we = 1'b0;
    step(2);
    check("mid_rst_mem_a", {480'd0, mem_a}, 512'd0);
    check("mid_rst_rdata", {480'd0, ls_rdata}, 512'd0);
    check("mid_rst_row", if_row, 512'd0);
    check("trunc_byte0", {504'd0, ram[960]}, {504'd0, 8'h44});
    check("trunc_byte1", {504'd0, ram[961]},
          {504'd0, init_val(961)});
    rst = 1'b0;
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
